charbuf_writer: RTL and testbench
=================================

CHARBUF_WRITER -- requirements
Module: charbuf_writer

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all logic.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_data, input, 8, character or control byte from the host source.
REQ-004 SHALL have port in_valid, input, 1, in_data is valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts a byte this cycle.
REQ-006 SHALL have port ada, output, 12, charbuf write address {row[5:0], col[5:0]}.
REQ-007 SHALL have port din, output, 8, charbuf write data.
REQ-008 SHALL have port cea, output, 1, charbuf write enable (one write per asserted cycle).
REQ-009 SHALL have ports cursor_row and cursor_col, output, 6 each, current cursor position.
REQ-010 SHALL have port busy, output, 1, clear sequence in progress.

Function
REQ-011 SHALL transfer a byte on any cycle with in_valid && in_ready; in_ready = 1 only in state IDLE.
REQ-012 SHALL implement the states IDLE and CLEAR; the CLEAR state writes 0x20 to consecutive addresses, one per cycle, with cea=1.
REQ-013 SHALL, for printable bytes 0x20..0x7E, drive ada={row,col}, din=byte, cea=1 on the cycle after the accept (latency 1), then col+1.
REQ-014 SHALL, when a printable byte is written at col 63, set col=0 and row=row+1 mod 64, then enter CLEAR for the 64 cells of the new row.
REQ-015 SHALL handle 0x0D (CR) by setting col=0, with no write.
REQ-016 SHALL handle 0x0A (LF) by setting row=row+1 mod 64 (row 63 wraps to 0), keeping col unchanged, then clearing the new row (64 cycles).
REQ-017 SHALL handle 0x08 (BS) by setting col=col-1 if col>0, with no write; BS at col 0 SHALL have no effect.
REQ-018 SHALL handle 0x0C (FF) by clearing all 4096 cells at addresses 0..4095 in ascending order, then setting the cursor to (0,0).
REQ-019 SHALL silently consume every other byte (0x00..0x1F not listed above, 0x7F..0xFF), with no write and no cursor change.
REQ-020 SHALL assert busy=1 exactly while in CLEAR; the first clear write SHALL occur on the cycle after the triggering accept.
REQ-021 SHALL return to IDLE the cycle after the last clear write; in_ready=1 in that cycle.
REQ-022 SHALL hold cea=0 on every cycle without a scheduled write; ada and din are don't-care when cea=0.
REQ-023 SHALL ignore in_valid while busy; the byte SHALL NOT be lost, because it is not accepted.

Reset
REQ-024 SHALL, on reset, set cea=0, cursor=(0,0), busy=0, in_ready=1 (state IDLE) on the next edge, except as REQ-026 specifies.
REQ-025 SHALL abort on reset asserted mid-CLEAR: no further writes from the cycle after reset; the partially cleared contents are retained.

Configuration
REQ-026 SHALL honour macro CHARBUF_WRITER_CLEAR_ON_RESET_EN: when defined, reset SHALL enter CLEAR for a full-screen clear (busy=1, in_ready=0 for 4096 cycles); when undefined, reset goes to IDLE as in REQ-024.

Structure
REQ-027 SHALL place in shared package charbuf_pkg: COLS=64, ROWS=64, ADDR_W=12, CLR_CHAR=8'h20, control codes CR/LF/BS/FF, and the state enum.
REQ-028 SHALL be a single module with no sub-module; the clear counter (12-bit) and the cursor registers live inline.

Verification
REQ-029 SHALL cover: after reset, send 'A' (0x41) -> next cycle cea=1, ada=0x000, din=0x41; then cursor_col=1.
REQ-030 SHALL cover: cursor (5,63), send 'Z' -> write at ada=0x17F, then cursor (6,0), busy=1 for 64 cycles writing 0x20 at 0x180..0x1BF.
REQ-031 SHALL cover: cursor (63,10), send LF -> cursor (0,10), clear 0x000..0x03F, busy for 64 cycles; a held in_valid is accepted only after busy falls.
REQ-032 SHALL cover: send FF -> 4096 writes of 0x20 at 0x000..0xFFF, cursor (0,0), in_ready=1 on the cycle after the last write.
REQ-033 SHALL cover: BS at col 0 -> no change; BS at col 3 -> col 2; bytes 0x07 and 0x80 -> no write, no cursor change.
REQ-034 SHALL cover: reset asserted at clear cycle 100 of an FF -> cea=0 from the next cycle, cursor (0,0); with CHARBUF_WRITER_CLEAR_ON_RESET_EN defined, a full clear restarts at 0x000.

Source files
------------

// File: rtl/charbuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : charbuf_pkg
//  Description : Shared constants, control codes and state encoding for the
//                character-buffer writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package charbuf_pkg;

  localparam int COLS   = 64;
  localparam int ROWS   = 64;
  localparam int ADDR_W = 12;

  localparam logic [7:0] CLR_CHAR = 8'h20;

  // Host control codes
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Bytes that land in the buffer as visible glyphs
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage
`default_nettype wire

// File: rtl/charbuf_writer.sv
`default_nettype none
// ============================================================================
//  Module      : charbuf_writer
//  Description : Turns a host byte stream into character-buffer writes with a
//                cursor, handling CR / LF / BS / FF and row / screen clears.
//                Optional macro CHARBUF_WRITER_CLEAR_ON_RESET_EN makes reset
//                start a full-screen clear instead of going idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module charbuf_writer
  import charbuf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ada,
  output logic [7:0]        din,
  output logic              cea,
  output logic [5:0]        cursor_row,
  output logic [5:0]        cursor_col,
  output logic              busy
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  state_t              r_state,    w_state;
  logic [ROW_W-1:0]    r_row,      w_row;
  logic [COL_W-1:0]    r_col,      w_col;
  logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr;
  logic                r_clr_full, w_clr_full;
  logic                r_wrap_pend, w_wrap_pend;
  logic                r_chr_wr,   w_chr_wr;
  logic [ADDR_W-1:0]   r_ada,      w_ada;
  logic [7:0]          r_din,      w_din;

  logic [ROW_W-1:0]    w_row_inc;
  logic                w_accept;
  logic                w_clr_done;

  assign w_row_inc = r_row + ROW_W'(1);
  // A wrap-pending character write holds off the host for one cycle
  // so that the row clear cannot overlap the glyph write.
  assign in_ready  = (r_state == ST_IDLE) && !r_wrap_pend;
  assign w_accept  = in_valid && in_ready;
  assign busy      = (r_state == ST_CLEAR);

  // Full clears stop at the top address, row clears at the last column
  assign w_clr_done = r_clr_full ? (r_clr_addr == {ADDR_W{1'b1}})
                                 : (r_clr_addr[COL_W-1:0] == {COL_W{1'b1}});

  // Clear writes come straight from the counter; glyph writes are registered
  assign cea        = r_chr_wr || busy;
  assign ada        = busy ? r_clr_addr : r_ada;
  assign din        = busy ? CLR_CHAR   : r_din;
  assign cursor_row = r_row;
  assign cursor_col = r_col;

  // Next-state, cursor and write scheduling
  always_comb begin
    w_state     = r_state;
    w_row       = r_row;
    w_col       = r_col;
    w_clr_addr  = r_clr_addr;
    w_clr_full  = r_clr_full;
    w_wrap_pend = r_wrap_pend;
    w_chr_wr    = 1'b0;
    w_ada       = r_ada;
    w_din       = r_din;

    case (r_state)
      ST_IDLE: begin
        if (r_wrap_pend) begin
          w_wrap_pend = 1'b0;
          w_state     = ST_CLEAR;
        end else if (w_accept) begin
          if (is_printable(in_data)) begin
            w_chr_wr = 1'b1;
            w_ada    = {r_row, r_col};
            w_din    = in_data;
            if (r_col == COL_W'(COLS - 1)) begin
              w_col       = '0;
              w_row       = w_row_inc;
              w_clr_addr  = {w_row_inc, {COL_W{1'b0}}};
              w_clr_full  = 1'b0;
              w_wrap_pend = 1'b1;
            end else begin
              w_col = r_col + COL_W'(1);
            end
          end else begin
            case (in_data)
              CR: w_col = '0;
              LF: begin
                w_row      = w_row_inc;
                w_clr_addr = {w_row_inc, {COL_W{1'b0}}};
                w_clr_full = 1'b0;
                w_state    = ST_CLEAR;
              end
              BS: if (r_col != '0) w_col = r_col - COL_W'(1);
              FF: begin
                w_clr_addr = '0;
                w_clr_full = 1'b1;
                w_state    = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        if (w_clr_done) begin
          w_state = ST_IDLE;
          if (r_clr_full) begin
            w_row = '0;
            w_col = '0;
          end
        end else begin
          w_clr_addr = r_clr_addr + ADDR_W'(1);
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset cancels any pending or ongoing write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_wrap_pend <= 1'b0;
      r_chr_wr    <= 1'b0;
      r_ada       <= '0;
      r_din       <= '0;
      r_clr_addr  <= '0;
`ifdef CHARBUF_WRITER_CLEAR_ON_RESET_EN
      r_state     <= ST_CLEAR;
      r_clr_full  <= 1'b1;
`else
      r_state     <= ST_IDLE;
      r_clr_full  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_row       <= w_row;
      r_col       <= w_col;
      r_clr_addr  <= w_clr_addr;
      r_clr_full  <= w_clr_full;
      r_wrap_pend <= w_wrap_pend;
      r_chr_wr    <= w_chr_wr;
      r_ada       <= w_ada;
      r_din       <= w_din;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_charbuf_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_charbuf_writer
//  Description : Scoreboard bench for charbuf_writer. Stimulus pushes the
//                expected charbuf writes; a negedge monitor pops and compares.
//                Honours CHARBUF_WRITER_CLEAR_ON_RESET_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_charbuf_writer;

  localparam int LIMIT = 6000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] ada;
  logic [7:0]  din;
  logic        cea;
  logic [5:0]  cursor_row;
  logic [5:0]  cursor_col;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [19:0] q[$];
  logic [5:0]  m_row = 6'd0;
  logic [5:0]  m_col = 6'd0;

  charbuf_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ada        (ada),
    .din        (din),
    .cea        (cea),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Monitor: every write the DUT presents must match the head of the queue
  always @(negedge clk) begin
    if (!reset && cea) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL write_unexpected: got ada=%03h din=%02h, none expected", ada, din);
      end else begin
        logic [19:0] e;
        e = q.pop_front();
        if ({ada, din} !== e) begin
          n_err++;
          $display("FAIL write: got ada=%03h din=%02h, expected ada=%03h din=%02h",
                   ada, din, e[19:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_row"}, int'(cursor_row), r);
    check({name, "_col"}, int'(cursor_col), c);
  endtask

  task automatic exp_clear_row(input logic [5:0] r);
    for (int c = 0; c < 64; c++) q.push_back({r, 6'(c), 8'h20});
  endtask

  task automatic exp_clear_all();
    for (int a = 0; a < 4096; a++) q.push_back({12'(a), 8'h20});
  endtask

  // Reference behaviour of one accepted byte
  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      q.push_back({m_row, m_col, b});
      if (m_col == 6'd63) begin
        m_col = 6'd0;
        m_row = m_row + 6'd1;
        exp_clear_row(m_row);
      end else begin
        m_col = m_col + 6'd1;
      end
    end else if (b == 8'h0D) begin
      m_col = 6'd0;
    end else if (b == 8'h0A) begin
      m_row = m_row + 6'd1;
      exp_clear_row(m_row);
    end else if (b == 8'h08) begin
      if (m_col != 6'd0) m_col = m_col - 6'd1;
    end else if (b == 8'h0C) begin
      exp_clear_all();
      m_row = 6'd0;
      m_col = 6'd0;
    end
  endtask

  // Present a byte, hold it until accepted; n_busy counts busy cycles waited.
  // Called and returns at posedge+1.
  task automatic send(input logic [7:0] b, output int n_busy);
    bit ok;
    ok = 0;
    n_busy = 0;
    model(b);
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      if (busy) n_busy++;
    end
    if (!ok) begin
      n_err++;
      $display("FAIL send_timeout: byte %02h never accepted", b);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send0(input logic [7:0] b);
    int nb;
    send(b, nb);
  endtask

  // Wait for in_ready; reports busy cycles and total cycles observed
  task automatic wait_ready(output int n_busy, output int n_cyc);
    bit ok;
    ok = 0;
    n_busy = 0;
    n_cyc = 0;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      n_cyc++;
      if (in_ready) begin
        ok = 1;
        break;
      end
      if (busy) n_busy++;
    end
    if (!ok) begin
      n_err++;
      $display("FAIL ready_timeout: in_ready never returned");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb, nc;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
`ifdef CHARBUF_WRITER_CLEAR_ON_RESET_EN
    exp_clear_all();
`endif
    #1 reset = 1'b0;
    @(negedge clk);
`ifdef CHARBUF_WRITER_CLEAR_ON_RESET_EN
    check("reset_busy", busy, 1);
    check("reset_ready", in_ready, 0);
    wait_ready(nb, nc);
    check("reset_clear_busy", nb, 4095);
`else
    check("reset_cea", cea, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", in_ready, 1);
    @(posedge clk);
    #1;
`endif
    check_cursor("reset_cursor", 0, 0);

    // ---------------- 'A' with latency 1 ----------------
    send0(8'h41);
    @(negedge clk);
    check("A_cea", cea, 1);
    check("A_ada", int'(ada), 0);
    check("A_din", int'(din), 8'h41);
    check_cursor("A_cursor", 0, 1);
    @(posedge clk);
    #1;

    // ---------------- wrap at (5,63) ----------------
    send0(8'h0D);
    for (int i = 0; i < 5; i++) send0(8'h0A);
    for (int i = 0; i < 63; i++) send0(8'h61 + 8'(i % 26));
    check_cursor("pre_Z", 5, 63);
    send0(8'h5A);
    wait_ready(nb, nc);
    check("Z_busy_cycles", nb, 64);
    check("Z_total_cycles", nc, 66);
    check_cursor("post_Z", 6, 0);

    // ---------------- LF at (63,10) with held in_valid ----------------
    for (int i = 0; i < 10; i++) send0(8'h62);
    for (int i = 0; i < 57; i++) send0(8'h0A);
    check_cursor("pre_LF", 63, 10);
    send0(8'h0A);
    send(8'h51, nb);
    check("LF_held_busy", nb, 64);
    check_cursor("post_LF_Q", 0, 11);

    // ---------------- BS and ignored bytes ----------------
    send0(8'h0D);
    send0(8'h08);
    check_cursor("BS_col0", 0, 0);
    for (int i = 0; i < 3; i++) send0(8'h63);
    send0(8'h08);
    check_cursor("BS_col3", 0, 2);
    send0(8'h07);
    check_cursor("ign_07", 0, 2);
    send0(8'h80);
    @(negedge clk);
    check("ign_80_cea", cea, 0);
    check_cursor("ign_80", 0, 2);
    @(posedge clk);
    #1;

    // ---------------- full FF clear ----------------
    send0(8'h0C);
    wait_ready(nb, nc);
    check("FF_busy", nb, 4096);
    check("FF_cycles", nc, 4097);
    check_cursor("post_FF", 0, 0);
    check("q_empty_FF", q.size(), 0);

    // ---------------- reset at clear cycle 100 ----------------
    send0(8'h0C);
    for (int i = 0; i < 100; i++) @(negedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_remaining", q.size(), 3996);
    q.delete();
    m_row = 6'd0;
    m_col = 6'd0;
`ifdef CHARBUF_WRITER_CLEAR_ON_RESET_EN
    exp_clear_all();
    @(negedge clk);
    check("abort_busy", busy, 1);
    wait_ready(nb, nc);
    check("abort_reclear_busy", nb, 4095);
`else
    @(negedge clk);
    check("abort_cea", cea, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 1);
    @(posedge clk);
    #1;
`endif
    check_cursor("abort_cursor", 0, 0);

    // Normal operation resumes
    send0(8'h42);
    @(negedge clk);
    check("resume_ada", int'(ada), 0);
    repeat (3) @(negedge clk);
    check("q_empty_end", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
